// File: rtl/or1200_pad_sched_if.sv
// Signal bundle between the decryption front-ends, the pad scheduler and
// the AES pad engine. The master side is the environment: requesters plus
// engine. The slave side is the scheduler.
interface or1200_pad_sched_if;
  // Port 0: load-store decryption
  logic         req0;
  logic [127:0] seed0;
  logic         ack0;
  logic [127:0] pad0;
  logic         err0;
  // Port 1: instruction-fetch decryption
  logic         req1;
  logic [127:0] seed1;
  logic         ack1;
  logic [127:0] pad1;
  logic         err1;
  // Cache control
  logic         flush;
  // Engine side
  logic         aes_ld;
  logic [127:0] aes_seed;
  logic         aes_done;
  logic [127:0] aes_pad;
  // Status
  logic         busy;

  modport master (
    output req0, seed0, req1, seed1, flush, aes_done, aes_pad,
    input  ack0, pad0, err0, ack1, pad1, err1, aes_ld, aes_seed, busy
  );

  modport slave (
    input  req0, seed0, req1, seed1, flush, aes_done, aes_pad,
    output ack0, pad0, err0, ack1, pad1, err1, aes_ld, aes_seed, busy
  );
endinterface

// File: rtl/or1200_pad_sched.sv
// Round-robin scheduler sharing one AES-128 pad engine between two
// decryption ports. Each port has a one-entry seed/pad cache, so a repeated
// seed is answered without starting the engine. A fill that takes too long
// is aborted with an error flag and invalidates that port's entry.
module or1200_pad_sched #(
  parameter int TIMEOUT = 63  // WAIT cycles before abort, 2..255
) (
  input  logic              clk,
  input  logic              rst,
  or1200_pad_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // The counter is cleared in LOAD and starts at 0 in the first WAIT cycle.
  // TIMEOUT WAIT cycles have elapsed when it reaches TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;

  logic [1:0]   req_w;
  logic [127:0] seed_w [2];

  logic         rr_ptr_q;
  logic         sel_port_q;
  logic [127:0] sel_seed_q;
  logic [127:0] aes_seed_q;
  logic [7:0]   wait_cnt_q;
  logic         err_q;

  logic [1:0]   valid_q;
  logic [127:0] tag_q  [2];
  logic [127:0] cpad_q [2];

  logic         grant_vld_w;
  logic         grant_port_w;
  logic         hit_w;
  logic         timeout_w;
  logic         fill_w;

  logic [1:0]         ack_w;
  logic [1:0]         err_w;
  logic [1:0][127:0]  pad_w;

  assign req_w     = {bus.req1, bus.req0};
  assign seed_w[0] = bus.seed0;
  assign seed_w[1] = bus.seed1;

  assign fill_w    = (state_q == WAIT) && bus.aes_done;
  assign timeout_w = (state_q == WAIT) && !bus.aes_done && (wait_cnt_q == WAIT_LAST);

  // Arbitration and cache lookup for the port that would be granted this cycle
  always_comb begin
    grant_vld_w  = |req_w;
    grant_port_w = req_w[1];
    if (&req_w) begin
      grant_port_w = rr_ptr_q;
    end
    // A flush in the same cycle forces a miss so a stale pad is never served
    hit_w = valid_q[grant_port_w] && !bus.flush &&
            (tag_q[grant_port_w] == seed_w[grant_port_w]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
        if (grant_vld_w) begin
          state_d = hit_w ? RESP : LOAD;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        state_d = WAIT;
        if (bus.aes_done || timeout_w) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, engine seed, wait counter and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= 1'b0;
      sel_port_q <= 1'b0;
      sel_seed_q <= '0;
      aes_seed_q <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_w) begin
            sel_port_q <= grant_port_w;
            sel_seed_q <= seed_w[grant_port_w];
            rr_ptr_q   <= ~grant_port_w;
            if (hit_w) begin
              err_q <= 1'b0;
            end else begin
              // Only misses touch the engine seed, so it stays stable for the engine
              aes_seed_q <= seed_w[grant_port_w];
            end
          end
        end
        LOAD: wait_cnt_q <= '0;
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (bus.aes_done) begin
            err_q <= 1'b0;
          end else if (timeout_w) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Seed/pad cache: filled on engine completion, dropped on timeout or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        cpad_q[i] <= '0;
      end
    end else begin
      if (fill_w) begin
        valid_q[sel_port_q] <= 1'b1;
        tag_q[sel_port_q]   <= sel_seed_q;
        cpad_q[sel_port_q]  <= bus.aes_pad;
      end else if (timeout_w) begin
        valid_q[sel_port_q] <= 1'b0;
      end
      // Flush wins over a simultaneous fill: the key just changed
      if (bus.flush) begin
        valid_q <= 2'b00;
      end
    end
  end

  // Per-port response: registered pad, state-decoded ack and error
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [127:0] pad_q;

    // Output pad updates only when that port is about to be acknowledged
    always_ff @(posedge clk) begin
      if (rst) begin
        pad_q <= '0;
      end else if ((state_q == IDLE) && grant_vld_w && hit_w &&
                   (grant_port_w == 1'(gi))) begin
        pad_q <= cpad_q[gi];
      end else if (fill_w && (sel_port_q == 1'(gi))) begin
        pad_q <= bus.aes_pad;
      end
    end

    assign pad_w[gi] = pad_q;
    assign ack_w[gi] = (state_q == RESP) && (sel_port_q == 1'(gi));
    assign err_w[gi] = ack_w[gi] && err_q;
  end

  assign bus.ack0     = ack_w[0];
  assign bus.pad0     = pad_w[0];
  assign bus.err0     = err_w[0];
  assign bus.ack1     = ack_w[1];
  assign bus.pad1     = pad_w[1];
  assign bus.err1     = err_w[1];
  assign bus.aes_ld   = (state_q == LOAD);
  assign bus.aes_seed = aes_seed_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_or1200_pad_sched.sv
// Bench for the pad scheduler: behavioural engine plus a per-port cache
// model that predicts ack timing, pad, error and engine use per request.
module tb_or1200_pad_sched;
  localparam int TO = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  or1200_pad_sched_if bus();

  or1200_pad_sched #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Engine model state
  int           eng_lat  = 12;  // cycles from aes_ld to aes_done, <0 never
  int           eng_cnt  = -1;
  logic [127:0] eng_seed = '0;

  // Reference model of the scheduler
  logic         m_valid [2];
  logic [127:0] m_tag   [2];
  logic [127:0] m_pad   [2];
  logic [127:0] m_out   [2];
  int           m_next;

  logic [127:0] pool [4];

  function automatic logic [127:0] eng_pad(input logic [127:0] s);
    return {8{16'hA5A5}} ^ s ^ 128'h1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_pad[i]   = '0;
      m_out[i]   = '0;
    end
    m_next = 0;
  endtask

  task automatic chk_idle_outs();
    chk("rst_ack0",  128'(bus.ack0),   128'(0));
    chk("rst_ack1",  128'(bus.ack1),   128'(0));
    chk("rst_err0",  128'(bus.err0),   128'(0));
    chk("rst_err1",  128'(bus.err1),   128'(0));
    chk("rst_ld",    128'(bus.aes_ld), 128'(0));
    chk("rst_busy",  128'(bus.busy),   128'(0));
    chk("rst_seed",  bus.aes_seed,     128'(0));
    chk("rst_pad0",  bus.pad0,         128'(0));
    chk("rst_pad1",  bus.pad1,         128'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.busy && n < 10);
    chk("idle", 128'(bus.busy), 128'(0));
  endtask

  // Engine: done pulse eng_lat cycles after aes_ld, random noise otherwise
  initial begin
    bus.aes_done = 1'b0;
    bus.aes_pad  = '0;
    forever begin
      @(posedge clk); #2;
      bus.aes_done = 1'b0;
      bus.aes_pad  = rand128();
      if (bus.aes_ld) begin
        eng_cnt  = eng_lat;
        eng_seed = bus.aes_seed;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.aes_done = 1'b1;
          bus.aes_pad  = eng_pad(eng_seed);
          eng_cnt      = -1;
        end
      end
    end
  end

  // One request on port p; flush_at is the cycle flush is high (-1 none)
  task automatic single(input int p, input logic [127:0] s, input int lat, input int flush_at);
    int cyc, ldn, ack_cyc, exp_ack, ev;
    logic exp_hit, exp_to, got_err, other_seen;
    logic [127:0] exp_pad, got_pad;
    wait_idle();
    exp_hit = m_valid[p] && (m_tag[p] == s) && (flush_at != 0);
    exp_to  = !exp_hit && (lat < 0);
    exp_ack = exp_hit ? 1 : (exp_to ? TO + 2 : lat + 2);
    exp_pad = exp_hit ? m_pad[p] : (exp_to ? m_out[p] : eng_pad(s));
    eng_lat = lat;
    if (p == 0) begin bus.req0 = 1'b1; bus.seed0 = s; end
    else        begin bus.req1 = 1'b1; bus.seed1 = s; end
    bus.flush = (flush_at == 0);
    cyc = 0; ldn = 0; ack_cyc = -1; got_pad = '0; got_err = 1'b0; other_seen = 1'b0;
    while (ack_cyc < 0 && cyc < TO + 20) begin
      @(posedge clk); #1;
      cyc++;
      bus.flush = (cyc == flush_at);
      if (bus.aes_ld) begin
        ldn++;
        chk("ld_cycle", 128'(cyc), 128'(1));
        chk("ld_seed", bus.aes_seed, s);
      end
      if (cyc == 1) chk("busy", 128'(bus.busy), 128'(1));
      if (p == 0 ? bus.ack1 : bus.ack0) other_seen = 1'b1;
      if (p == 0 ? bus.ack0 : bus.ack1) begin
        ack_cyc = cyc;
        got_pad = (p == 0) ? bus.pad0 : bus.pad1;
        got_err = (p == 0) ? bus.err0 : bus.err1;
      end
    end
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.flush = 1'b0;
    chk("ack_cycle", 128'(ack_cyc), 128'(exp_ack));
    chk("pad", got_pad, exp_pad);
    chk("err", 128'(got_err), 128'(exp_to));
    chk("ld_count", 128'(ldn), 128'(exp_hit ? 0 : 1));
    chk("other_ack", 128'(other_seen), 128'(0));
    // Model update
    if (exp_to) begin
      m_valid[p] = 1'b0;
    end else if (!exp_hit) begin
      m_valid[p] = 1'b1;
      m_tag[p]   = s;
      m_pad[p]   = exp_pad;
    end
    if (!exp_to) m_out[p] = exp_pad;
    ev = exp_hit ? 0 : lat + 1;
    if (flush_at >= 0 && flush_at < exp_ack) begin
      m_valid[1 - p] = 1'b0;
      if (flush_at >= ev) m_valid[p] = 1'b0;
    end
    m_next = 1 - p;
    $display("txn port=%0d seed=%h hit=%0d ack@%0d err=%0d ld=%0d flush@%0d",
             p, s, exp_hit, ack_cyc, got_err, ldn, flush_at);
  endtask

  // Both ports request continuously with fresh seeds for four grants
  task automatic dual();
    logic [127:0] sd [2];
    logic [127:0] got_pad;
    int exp_p, got_p, done_n, ldn, cyc;
    wait_idle();
    eng_lat = $urandom_range(1, 8);
    sd[0] = rand128();
    sd[1] = rand128();
    bus.seed0 = sd[0]; bus.seed1 = sd[1];
    bus.req0  = 1'b1;  bus.req1  = 1'b1;
    exp_p = m_next; done_n = 0; ldn = 0; cyc = 0;
    while (done_n < 4 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.aes_ld) begin
        ldn++;
        chk("dual_ld_seed", bus.aes_seed, sd[exp_p]);
      end
      if (bus.ack0 || bus.ack1) begin
        chk("dual_one_ack", 128'(bus.ack0 & bus.ack1), 128'(0));
        got_p   = bus.ack1 ? 1 : 0;
        got_pad = (got_p == 1) ? bus.pad1 : bus.pad0;
        chk("dual_order", 128'(got_p), 128'(exp_p));
        chk("dual_pad", got_pad, eng_pad(sd[got_p]));
        chk("dual_err", 128'((got_p == 1) ? bus.err1 : bus.err0), 128'(0));
        $display("txn dual port=%0d seed=%h ack@%0d", got_p, sd[got_p], cyc);
        m_valid[got_p] = 1'b1;
        m_tag[got_p]   = sd[got_p];
        m_pad[got_p]   = eng_pad(sd[got_p]);
        m_out[got_p]   = eng_pad(sd[got_p]);
        done_n++;
        m_next = 1 - got_p;
        exp_p  = m_next;
        sd[got_p] = rand128();
        if (got_p == 1) bus.seed1 = sd[1];
        else            bus.seed0 = sd[0];
        if (done_n == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("dual_acks", 128'(done_n), 128'(4));
    chk("dual_ld_count", 128'(ldn), 128'(4));
  endtask

  // Reset while waiting on the engine; its late done must be ignored
  task automatic reset_mid_wait();
    int acks;
    wait_idle();
    eng_lat   = 10;
    bus.req0  = 1'b1;
    bus.seed0 = rand128();
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_busy_pre", 128'(bus.busy), 128'(1));
    rst      = 1'b1;
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle_outs();
    m_reset();
    acks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.ack0 || bus.ack1 || bus.busy) acks++;
    end
    chk("rst_late_done", 128'(acks), 128'(0));
    $display("txn reset-in-wait activity=%0d", acks);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.seed0 = '0;
    bus.req1 = 1'b0; bus.seed1 = '0;
    bus.flush = 1'b0;
    m_reset();
    pool[0] = 128'h1;
    pool[1] = 128'h2;
    pool[2] = rand128();
    pool[3] = 128'h0;

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs();
    rst = 1'b0;

    single(0, 128'h1, 12, -1);   // miss, ack at 14
    single(0, 128'h1, 12, -1);   // hit, ack at 1
    single(1, 128'h1, 3, -1);    // port 1 cache is separate: miss
    dual();                      // ping-pong 0,1,0,1
    single(1, 128'h77, 5, -1);   // fill port 1
    single(1, 128'h88, -1, -1);  // timeout, invalidates port 1 entry
    single(1, 128'h77, 5, -1);   // now misses
    single(0, 128'h55, 6, 7);    // flush coincides with fill
    single(0, 128'h55, 6, -1);   // misses after flush
    single(0, 128'h55, 3, 0);    // cached, but flush in IDLE forces miss

    for (int i = 0; i < 24; i++) begin
      int p, lat, fl;
      p   = int'($urandom_range(0, 1));
      lat = int'($urandom_range(1, 20));
      fl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat + 1)) : -1;
      single(p, pool[$urandom_range(0, 3)], lat, fl);
    end

    reset_mid_wait();
    single(0, 128'h0, 3, -1);    // reset tags are 0 but invalid: miss

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/or1200_pad_sched.md
# or1200_pad_sched

Scheduler that shares one AES-128 pad engine between two requesters, port 0 (load-store decryption) and port 1 (instruction-fetch decryption). It arbitrates round-robin and issues a one-cycle load pulse with the winning seed. It waits for the engine's done, then returns the 128-bit pad to the granted port. A one-entry seed/pad cache per port skips the engine when the seed repeats. It sits between the encryption front-ends and the `aes_cipher_top` instance, and drives that core's `ld` and `text_in`.

## Interface
Parameters:
- TIMEOUT, 63: maximum cycles spent in WAIT before the request is aborted with error; range 2..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0  in  1  port 0 request; held high with seed0 stable until ack0.
- seed0  in  128  port 0 seed.
- ack0  out  1  one-cycle pulse; pad0/err0 valid in this cycle.
- pad0  out  128  port 0 pad, registered, held until next ack0.
- err0  out  1  timeout flag, valid with ack0 only.
- req1/seed1/ack1/pad1/err1  same as port 0, for port 1.
- flush  in  1  invalidate both cache entries (key change).
- aes_ld  out  1  one-cycle load pulse to the engine.
- aes_seed  out  128  registered seed to the engine, stable from LOAD through WAIT.
- aes_done  in  1  engine completion pulse.
- aes_pad  in  128  engine result, valid when aes_done is high.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, WAIT, RESP; 2-bit encoding; default branch returns to IDLE.
- **IDLE**
  - Requests are sampled only in IDLE.
  - With only one req high, that port is granted.
  - With both high, the port indicated by rr_ptr is granted.
  - On every grant, rr_ptr becomes the other port.
  - The granted seed is latched into sel_seed and the port index into sel_port.
- **Hit check** (in IDLE, on the granted port):
  - Hit: entry valid and seed equals tag. Go to RESP with the cached pad; aes_ld is not asserted.
  - Miss: go to LOAD.
- **LOAD:** aes_ld=1 for exactly this cycle, aes_seed=sel_seed; go to WAIT; clear wait counter.
- **WAIT:**
  - On aes_done: capture aes_pad into pad[sel_port], tag[sel_port]←sel_seed, valid[sel_port]←1, err←0; go to RESP.
  - If the counter reaches TIMEOUT with aes_done still low: valid[sel_port]←0, pad[sel_port] unchanged, err←1; go to RESP.
  - The counter increments once per WAIT cycle.
- **RESP:** ack[sel_port]=1 and err[sel_port] as set; the other port's ack stays 0; go to IDLE.
- aes_done outside WAIT is ignored.
- Requester rule: deassert req in the cycle after ack, unless issuing a new request. A req still high in the IDLE cycle after RESP is a new request.
- **Flush** clears both valid bits in any state.
  - If flush coincides with a WAIT fill, valid stays 0; the pad is still returned with err=0.
  - If flush is high in IDLE, that cycle's hit check reports miss.
- **Reset values**
  - State IDLE, rr_ptr=0, valid=00, tags 0, pad0/pad1 0.
  - ack0/ack1/err0/err1/aes_ld/busy 0, aes_seed 0.
  - Reset mid-operation abandons the transaction without ack. An aes_done arriving afterwards is ignored.

## Timing
- Request sampled in IDLE at cycle 0.
- **Hit:** RESP and ack at cycle 1; 2 cycles busy-to-idle.
- **Miss:** aes_ld at cycle 1; aes_done first sampled in WAIT at cycle 2.
  - If aes_done is seen in cycle k≥2, ack is at k+1.
- **Timeout:** ack with err=1 at cycle TIMEOUT+2.
- All outputs are registered or state-decoded; no combinational path from req/seed to ack.
- Back-to-back throughput on hits: one ack every 2 cycles.
- Ping-pong order under simultaneous requests: 0,1,0,1…

## Test plan
- Reset, then req0 with seed0=128'h1; model done 12 cycles after aes_ld, aes_pad=128'hA5…A5.
  - Expect aes_ld at cycle 1 with aes_seed=1.
  - Expect ack0 at cycle 14 with pad0=A5…A5, err0=0.
- Repeat the same seed0=1.
  - Expect ack0 at cycle 1 with pad A5…A5.
  - Expect no aes_ld pulse.
- req0 and req1 raised simultaneously and held for 4 transactions, all misses.
  - Expect grant order 0,1,0,1.
  - Expect exactly one aes_ld per transaction; never both acks high.
- Engine never asserts done, TIMEOUT=63.
  - Expect ack with err=1 at cycle 65.
  - The entry is invalidated, so the next identical seed misses.
- Flush asserted during WAIT of a fill.
  - The pad is returned with err=0.
  - The following identical seed misses and issues aes_ld.
- rst asserted during WAIT, then aes_done pulses.
  - All outputs are 0 and state is IDLE.
  - The late aes_done produces no ack.
